// File: rtl/crc_stream_pkg.sv
// rtl/crc_stream_pkg.sv - shared types and helpers for the streaming CRC encoder
package crc_stream_pkg;

    localparam int CRC_W_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Reverses the low 'width' bits of v; bits at and above 'width' return zero.
    function automatic logic [CRC_W_MAX-1:0] reverse_crc(input logic [CRC_W_MAX-1:0] v,
                                                         input int width);
        logic [CRC_W_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < CRC_W_MAX; i++) begin
            if (i < width) r[i] = v[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_fold_step.sv
// rtl/crc_fold_step.sv - combinational fold of BITS message bits into a CRC, MSB of bits first
module crc_fold_step #(
    parameter int CRC_W = 8,
    parameter int BITS  = 1
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [CRC_W-1:0] poly,
    input  logic [BITS-1:0]  bits,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] c;
    logic             fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = BITS - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ bits[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_stream_encoder.sv
// rtl/crc_stream_encoder.sv - streaming CRC generator with runtime poly/init/xorout/reflection
module crc_stream_encoder
    import crc_stream_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int CRC_W          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic [CRC_W-1:0]  cfg_poly,
    input  logic [CRC_W-1:0]  cfg_init,
    input  logic [CRC_W-1:0]  cfg_xorout,
    input  logic              cfg_refin,
    input  logic              cfg_refout,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CRC_W-1:0]  m_crc
);

    localparam int N     = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t              state, state_nxt;
    logic [CRC_W-1:0]    crc, crc_nxt, crc_final;
    logic [CRC_W-1:0]    poly_q, xorout_q;
    logic                refin_q, refout_q, last_q, refin_sel;
    logic [DATA_W-1:0]   beat_q, beat_in;
    logic [CNT_W-1:0]    cnt;
    logic [CRC_W_MAX-1:0] crc_ext;
    logic                shift_done;

    assign s_ready    = (state == ST_IDLE) || (state == ST_WAIT);
    assign m_valid    = (state == ST_DONE);
    assign shift_done = (state == ST_SHIFT) && (cnt == CNT_LAST);

    // Reflected input is reversed once at capture so the fold always runs MSB first.
    always_comb begin
        refin_sel = (state == ST_IDLE) ? cfg_refin : refin_q;
        beat_in   = s_data;
        if (refin_sel) begin
            for (int i = 0; i < DATA_W; i++) beat_in[i] = s_data[DATA_W-1-i];
        end
    end

    crc_fold_step #(
        .CRC_W (CRC_W),
        .BITS  (BITS_PER_CYCLE)
    ) u_fold (
        .crc_in  (crc),
        .poly    (poly_q),
        .bits    (beat_q[DATA_W-1 -: BITS_PER_CYCLE]),
        .crc_out (crc_nxt)
    );

    always_comb begin
        crc_ext            = '0;
        crc_ext[CRC_W-1:0] = crc_nxt;
        crc_final = (refout_q ? CRC_W'(reverse_crc(crc_ext, CRC_W)) : crc_nxt) ^ xorout_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (s_valid) state_nxt = ST_SHIFT;
            ST_SHIFT: if (shift_done) state_nxt = last_q ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (s_valid) state_nxt = ST_SHIFT;
            ST_DONE:  if (m_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (clr) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crc      <= '0;
            cnt      <= '0;
            m_crc    <= '0;
            poly_q   <= '0;
            xorout_q <= '0;
            refin_q  <= 1'b0;
            refout_q <= 1'b0;
            last_q   <= 1'b0;
            beat_q   <= '0;
        end else if (clr) begin
            crc   <= '0;
            cnt   <= '0;
            m_crc <= '0;
        end else begin
            case (state)
                ST_IDLE: if (s_valid) begin
                    poly_q   <= cfg_poly;
                    xorout_q <= cfg_xorout;
                    refin_q  <= cfg_refin;
                    refout_q <= cfg_refout;
                    crc      <= cfg_init;
                    beat_q   <= beat_in;
                    last_q   <= s_last;
                    cnt      <= '0;
                end
                ST_SHIFT: begin
                    crc    <= crc_nxt;
                    beat_q <= beat_q << BITS_PER_CYCLE;
                    if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                    if (shift_done && last_q) m_crc <= crc_final;
                end
                ST_WAIT: if (s_valid) begin
                    beat_q <= beat_in;
                    last_q <= s_last;
                    cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream_encoder.sv
// tb/tb_crc_stream_encoder.sv - scoreboard bench for crc_stream_encoder (CRC-8 x2, CRC-16)
module tb_crc_stream_encoder;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic [2:0]  sv = 3'b000;
    logic [2:0]  mr = 3'b111;
    wire  [2:0]  sr;
    wire  [2:0]  mv;

    logic [7:0]  c8_poly = 8'h07, c8_init = 8'h00, c8_xor = 8'h00;
    logic        c8_refin = 1'b0, c8_refout = 1'b0;
    logic [15:0] c16_poly = 16'h1021, c16_init = 16'hFFFF, c16_xor = 16'h0000;
    logic        c16_refin = 1'b0, c16_refout = 1'b0;

    wire  [7:0]  crc0, crc1;
    wire  [15:0] crc2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc [3];
    logic [2:0] mv_prev = 3'b000;

    typedef struct {
        int          dut;
        logic [31:0] crc;
    } exp_t;
    exp_t expq [$];
    exp_t mon_e;

    crc_stream_encoder #(.DATA_W(8), .CRC_W(8), .BITS_PER_CYCLE(1)) u_c8s (
        .clk(clk), .resetn(resetn), .clr(clr),
        .cfg_poly(c8_poly), .cfg_init(c8_init), .cfg_xorout(c8_xor),
        .cfg_refin(c8_refin), .cfg_refout(c8_refout),
        .s_valid(sv[0]), .s_ready(sr[0]), .s_data(s_data), .s_last(s_last),
        .m_valid(mv[0]), .m_ready(mr[0]), .m_crc(crc0)
    );

    crc_stream_encoder #(.DATA_W(8), .CRC_W(8), .BITS_PER_CYCLE(8)) u_c8f (
        .clk(clk), .resetn(resetn), .clr(clr),
        .cfg_poly(c8_poly), .cfg_init(c8_init), .cfg_xorout(c8_xor),
        .cfg_refin(c8_refin), .cfg_refout(c8_refout),
        .s_valid(sv[1]), .s_ready(sr[1]), .s_data(s_data), .s_last(s_last),
        .m_valid(mv[1]), .m_ready(mr[1]), .m_crc(crc1)
    );

    crc_stream_encoder #(.DATA_W(8), .CRC_W(16), .BITS_PER_CYCLE(4)) u_c16 (
        .clk(clk), .resetn(resetn), .clr(clr),
        .cfg_poly(c16_poly), .cfg_init(c16_init), .cfg_xorout(c16_xor),
        .cfg_refin(c16_refin), .cfg_refout(c16_refout),
        .s_valid(sv[2]), .s_ready(sr[2]), .s_data(s_data), .s_last(s_last),
        .m_valid(mv[2]), .m_ready(mr[2]), .m_crc(crc2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] crc_of(input int d);
        case (d)
            0:       return {24'h0, crc0};
            1:       return {24'h0, crc1};
            default: return {16'h0, crc2};
        endcase
    endfunction

    function automatic int lat_of(input int d);
        case (d)
            0:       return 8;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per output handshake, checks latency on m_valid rise.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (resetn && mv[d] && !mv_prev[d])
                chk($sformatf("latency dut%0d", d), 32'(cyc - last_acc[d]), 32'(lat_of(d)));
            if (resetn && mv[d] && mr[d]) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected result dut%0d: got 0x%0h expected none", d, crc_of(d));
                end else begin
                    mon_e = expq.pop_front();
                    chk($sformatf("result dut id dut%0d", d), 32'(d), 32'(mon_e.dut));
                    chk($sformatf("crc dut%0d", d), crc_of(d), mon_e.crc);
                end
            end
        end
        mv_prev = mv;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic [31:0] c);
        exp_t e;
        e.dut = d;
        e.crc = c;
        expq.push_back(e);
    endtask

    task automatic send(input int d, input logic [7:0] data, input logic last);
        int t;
        t = 0;
        sv[d]  = 1'b1;
        s_data = data;
        s_last = last;
        @(negedge clk);
        while (!sr[d] && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++;
            errors++;
            $display("FAIL s_ready timeout dut%0d: got 0 expected 1", d);
        end
        step();
        if (last) last_acc[d] = cyc;
        sv[d] = 1'b0;
    endtask

    task automatic send_123(input int d);
        for (int i = 0; i < 9; i++) send(d, 8'(8'h31 + i), i == 8);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain timeout: got %0d pending expected 0", expq.size());
        end
        step();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset s_ready dut%0d", d), 32'(sr[d]), 32'd1);
            chk($sformatf("reset m_valid dut%0d", d), 32'(mv[d]), 32'd0);
            chk($sformatf("reset m_crc dut%0d", d), crc_of(d), 32'd0);
        end
        step();
        resetn = 1'b1;
        step();

        // CRC-8 "123456789", one bit per cycle
        push(0, 32'hF4);
        send_123(0);
        drain();

        // result backpressure; next message must wait for m_ready
        mr[0] = 1'b0;
        push(0, 32'h07);
        send(0, 8'h01, 1'b1);
        begin
            int t;
            t = 0;
            while (!mv[0] && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("m_valid arrival", 32'(mv[0]), 32'd1);
        end
        step();
        sv[0] = 1'b1;
        s_data = 8'h02;
        s_last = 1'b1;
        push(0, 32'h0E);
        repeat (5) begin
            @(negedge clk);
            chk("stall m_valid", 32'(mv[0]), 32'd1);
            chk("stall m_crc", 32'(crc0), 32'h07);
            chk("stall s_ready", 32'(sr[0]), 32'd0);
        end
        step();
        mr[0] = 1'b1;
        send(0, 8'h02, 1'b1);
        drain();

        // poly change mid-message is ignored, picked up by the next message
        push(0, 32'hF4);
        for (int i = 0; i < 9; i++) begin
            if (i == 3) c8_poly = 8'h31;
            send(0, 8'(8'h31 + i), i == 8);
        end
        push(0, 32'h31);
        send(0, 8'h01, 1'b1);
        drain();
        c8_poly = 8'h07;

        // clr during SHIFT of beat 5
        for (int i = 0; i < 5; i++) send(0, 8'(8'h31 + i), 1'b0);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        chk("clr s_ready", 32'(sr[0]), 32'd1);
        chk("clr m_valid", 32'(mv[0]), 32'd0);
        chk("clr m_crc", 32'(crc0), 32'd0);
        step();
        push(0, 32'hF4);
        send_123(0);
        drain();

        // reset pulse during SHIFT of beat 5
        for (int i = 0; i < 5; i++) send(0, 8'(8'h31 + i), 1'b0);
        step();
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset s_ready", 32'(sr[0]), 32'd1);
        chk("midreset m_valid", 32'(mv[0]), 32'd0);
        chk("midreset m_crc", 32'(crc0), 32'd0);
        step();
        resetn = 1'b1;
        step();
        push(0, 32'hF4);
        send_123(0);
        drain();

        // back-to-back single-beat messages
        push(0, 32'h07);
        send(0, 8'h01, 1'b1);
        push(0, 32'h0E);
        send(0, 8'h02, 1'b1);
        drain();

        // CRC-8 byte per cycle
        push(1, 32'hF4);
        send_123(1);
        drain();

        // CRC-16/CCITT-FALSE then CRC-16/ARC
        push(2, 32'h29B1);
        send_123(2);
        drain();
        c16_poly   = 16'h8005;
        c16_init   = 16'h0000;
        c16_refin  = 1'b1;
        c16_refout = 1'b1;
        push(2, 32'hBB3D);
        send_123(2);
        drain();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_stream_encoder.md
Name: crc_stream_encoder

Overview:
- Parametrised, streaming CRC generator. Accepts a message of one or more DATA_W-bit beats over a valid/ready handshake and folds BITS_PER_CYCLE bits per clock into the CRC register.
- Returns the final CRC on a valid/ready result port.
- Polynomial, init value, final XOR and bit reflection are runtime-configurable and latched at message start.
- Sits between the packet framer and the CRC append/compare logic; replaces the fixed single-word encoder.

Parameters:
- DATA_W, 8: beat width in bits; must be a multiple of BITS_PER_CYCLE.
- CRC_W, 8: CRC width, 3..32.
- BITS_PER_CYCLE, 1: message bits folded per clock; 1, 2, 4 or 8; divides DATA_W.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort; returns block to IDLE, drops any partial message
- cfg_poly  in  CRC_W  generator polynomial; implicit x^CRC_W term omitted
- cfg_init  in  CRC_W  CRC register preset
- cfg_xorout  in  CRC_W  final XOR mask
- cfg_refin  in  1  1 = each beat processed LSB first
- cfg_refout  in  1  1 = CRC bit-reversed before final XOR
- s_valid  in  1  beat valid
- s_ready  out  1  block can accept a beat
- s_data  in  DATA_W  beat data
- s_last  in  1  beat is the final beat of the message
- m_valid  out  1  CRC result valid
- m_ready  in  1  consumer accepts result
- m_crc  out  CRC_W  final CRC

Behaviour:
- Algorithm: standard direct (non-augmented) CRC, equal to message·x^CRC_W mod G.
  - Per bit b: fb = crc[CRC_W-1]^b; crc = (crc<<1) ^ (fb ? poly : 0).
  - MSB of beat first unless cfg_refin.
- Reset (async) and clr: state=IDLE, crc=0, counter=0, s_ready=1, m_valid=0, m_crc=0.
- FSM states IDLE, SHIFT, WAIT, DONE:
  - IDLE: s_ready=1. On s_valid, latch cfg_*, load crc=cfg_init, capture beat and last flag, go SHIFT.
  - SHIFT: s_ready=0. Folds BITS_PER_CYCLE bits per edge for N=DATA_W/BITS_PER_CYCLE edges. After the Nth edge go DONE if the last flag is set, else WAIT.
  - WAIT: s_ready=1. On s_valid, capture beat and last flag, go SHIFT; crc and cfg are retained.
  - DONE: m_valid=1, m_crc = (refout ? reverse(crc) : crc) ^ xorout, registered. On m_ready go IDLE.
- Latency: m_valid rises exactly N edges after the accept edge of the last beat. Per-beat throughput is one beat per N+1 cycles.
- cfg_* changes mid-message are ignored until the next IDLE accept.
- Backpressure: in DONE, s_ready=0; a pending s_valid waits. m_crc is stable while m_valid && !m_ready.
- Simultaneous clr with any handshake: clr wins, the beat is not accepted, the result is dropped.
- Reset asserted mid-message: the message is lost, outputs return to reset values immediately.
- Single-beat messages are legal (s_last on the first beat). Zero-length messages are not supported.
- Counter width: $clog2(N)+1; no wrap beyond N-1.

Decomposition:
- Package crc_stream_pkg: state enum type, a function returning the bit-reverse of a CRC_W vector, and a localparam for the maximum CRC_W.
- One sub-module, crc_fold_step: combinational; takes crc, poly and BITS_PER_CYCLE input bits, returns the next crc. It is instantiated once and reused every SHIFT cycle.

Test Plan:
- CRC-8 (poly 0x07, init 0x00, xorout 0x00, no reflection), DATA_W=8, 9 beats "123456789" (0x31..0x39), last on 0x39 -> m_crc=0xF4; m_valid 8 cycles after last accept at BITS_PER_CYCLE=1, 1 cycle at BITS_PER_CYCLE=8.
- CRC_W=16 instance, poly 0x1021, init 0xFFFF, xorout 0, same message -> 0x29B1. With cfg_refin=cfg_refout=1, poly 0x8005, init 0 (CRC-16/ARC) -> 0xBB3D.
- CRC-8 single beat 0x01 with s_last -> m_crc=0x07. Hold m_ready=0 for 5 cycles -> m_valid and m_crc stable, s_ready=0; next message's s_valid waits until m_ready.
- Change cfg_poly to 0x31 between beats 3 and 4 of the "123456789" message -> result still 0xF4. The following message uses 0x31.
- Assert clr during SHIFT of beat 5, then send "123456789" -> 0xF4, no stale m_valid. Repeat with resetn pulsed low mid-SHIFT -> all outputs at reset values during reset.
- Back-to-back messages 0x01 then 0x02, m_ready tied 1 -> results 0x07 then 0x0E, in order, none lost.
